// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and fixed wait-state access sequencer for
// the single-port data memory. One access is in flight at a time; the
// winner's request fields are latched so the master may drop req mid-access.
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        last_grant_reg;
    logic        winner_reg;
    logic        we_reg;
    logic        oor_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata0_reg;
    logic [31:0] rdata1_reg;
    logic [1:0]  ack_reg;
    logic [1:0]  err_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        busy_reg;

    logic        grant_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oor;

    // Pick the winner: a lone requester wins, a tie goes to the master not granted last.
    always_comb begin
        grant_id = 1'b0;
        if (m0_req && m1_req) begin
            grant_id = ~last_grant_reg;
        end else if (m1_req) begin
            grant_id = 1'b1;
        end
        sel_we    = grant_id ? m1_we    : m0_we;
        sel_addr  = grant_id ? m1_addr  : m0_addr;
        sel_wdata = grant_id ? m1_wdata : m0_wdata;
        sel_oor   = (sel_addr >= DEPTH_W);
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            last_grant_reg <= 1'b1;
            winner_reg     <= 1'b0;
            we_reg         <= 1'b0;
            oor_reg        <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            rdata0_reg     <= 32'd0;
            rdata1_reg     <= 32'd0;
            ack_reg        <= 2'b00;
            err_reg        <= 2'b00;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        winner_reg    <= grant_id;
                        we_reg        <= sel_we;
                        addr_reg      <= sel_addr;
                        wdata_reg     <= sel_wdata;
                        oor_reg       <= sel_oor;
                        cnt_reg       <= WAIT_INIT;
                        state_reg     <= ACCESS;
                        busy_reg      <= 1'b1;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_wdata;
                        mem_read_reg  <= !sel_we && !sel_oor;
                        // With no wait states the first ACCESS cycle is also the commit cycle.
                        mem_write_reg <= sel_we && !sel_oor && (WAIT_INIT == 4'd0);
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= RESP;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= 32'd0;
                        mem_wdata_reg <= 32'd0;
                        ack_reg[winner_reg] <= 1'b1;
                        err_reg[winner_reg] <= oor_reg;
                        // Reads capture memory data (or zero when out of range); writes leave rdata alone.
                        if (!we_reg) begin
                            if (winner_reg) begin
                                rdata1_reg <= oor_reg ? 32'd0 : mem_rdata;
                            end else begin
                                rdata0_reg <= oor_reg ? 32'd0 : mem_rdata;
                            end
                        end
                    end else begin
                        cnt_reg       <= cnt_reg - 4'd1;
                        // Raise write enable only for the final ACCESS cycle: one commit edge.
                        mem_write_reg <= we_reg && !oor_reg && (cnt_reg == 4'd1);
                    end
                end
                RESP: begin
                    ack_reg        <= 2'b00;
                    err_reg        <= 2'b00;
                    busy_reg       <= 1'b0;
                    last_grant_reg <= winner_reg;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m0_ack    = ack_reg[0];
    assign m1_ack    = ack_reg[1];
    assign m0_err    = err_reg[0];
    assign m1_err    = err_reg[1];
    assign m0_rdata  = rdata0_reg;
    assign m1_rdata  = rdata1_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (WAIT = 0, 3, 2) each with its own
// memory model; expected acknowledges are queued as stimulus is issued.
module tb_dmem_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    logic        m0_req [NI];
    logic        m0_we [NI];
    logic [31:0] m0_addr [NI];
    logic [31:0] m0_wdata [NI];
    logic        m0_ack [NI];
    logic        m0_err [NI];
    logic [31:0] m0_rdata [NI];
    logic        m1_req [NI];
    logic        m1_we [NI];
    logic [31:0] m1_addr [NI];
    logic [31:0] m1_wdata [NI];
    logic        m1_ack [NI];
    logic        m1_err [NI];
    logic [31:0] m1_rdata [NI];
    logic        mem_read [NI];
    logic        mem_write [NI];
    logic [31:0] mem_addr [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy [NI];

    typedef struct {
        int          inst;
        int          m;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [NI][64];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
        logic [31:0] mem [64];
        int wr_cnt = 0;
        int rd_cnt = 0;

        dmem_arbiter #(.DEPTH(64), .WAIT(W)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req[gi]), .m0_we(m0_we[gi]), .m0_addr(m0_addr[gi]),
            .m0_wdata(m0_wdata[gi]), .m0_ack(m0_ack[gi]), .m0_err(m0_err[gi]),
            .m0_rdata(m0_rdata[gi]),
            .m1_req(m1_req[gi]), .m1_we(m1_we[gi]), .m1_addr(m1_addr[gi]),
            .m1_wdata(m1_wdata[gi]), .m1_ack(m1_ack[gi]), .m1_err(m1_err[gi]),
            .m1_rdata(m1_rdata[gi]),
            .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
            .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]),
            .mem_rdata(mem_rdata[gi]), .busy(busy[gi])
        );

        // Combinational-read memory model with enable-cycle counters.
        assign mem_rdata[gi] = mem[mem_addr[gi][5:0]];
        always @(posedge clk) begin
            if (mem_write[gi]) begin
                mem[mem_addr[gi][5:0]] <= mem_wdata[gi];
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_read[gi]) rd_cnt <= rd_cnt + 1;
        end
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int inst, input int m, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req[inst] = 1'b1; m0_we[inst] = we; m0_addr[inst] = addr; m0_wdata[inst] = wdata;
        end else begin
            m1_req[inst] = 1'b1; m1_we[inst] = we; m1_addr[inst] = addr; m1_wdata[inst] = wdata;
        end
    endtask

    // Queue the expected response and advance the reference memory.
    task automatic push_exp(input int inst, input int m, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata, input int due);
        exp_t e;
        e.inst   = inst;
        e.m      = m;
        e.err    = (addr >= 32'd64);
        e.chk_rd = !we;
        e.rdata  = e.err ? 32'd0 : ref_mem[inst][addr[5:0]];
        e.due    = due;
        if (we && !e.err) ref_mem[inst][addr[5:0]] = wdata;
        exp_q.push_back(e);
    endtask

    // Drive a single request just after a clock edge, expecting it to be sampled at the next one.
    task automatic issue(input int inst, input int m, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        set_req(inst, m, we, addr, wdata);
        push_exp(inst, m, we, addr, wdata, cyc + wait_of(inst) + 2);
    endtask

    // Wait (bounded) for an ack on an instance and compare it with the queue head.
    task automatic wait_ack(input int inst, input logic [1:0] drop);
        bit got = 0;
        exp_t e;
        int obs_m;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (m0_ack[inst] || m1_ack[inst]) got = 1;
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        obs_m = m1_ack[inst] ? 1 : 0;
        check("grant", 32'(obs_m), 32'(e.m));
        check("latency", 32'(cyc), 32'(e.due));
        check("err", {31'd0, (e.m == 1) ? m1_err[inst] : m0_err[inst]}, {31'd0, e.err});
        if (e.chk_rd) check("rdata", (e.m == 1) ? m1_rdata[inst] : m0_rdata[inst], e.rdata);
        $display("txn inst=%0d master=%0d err=%0b rdata=%h cycle=%0d", inst, obs_m,
                 (obs_m == 1) ? m1_err[inst] : m0_err[inst],
                 (obs_m == 1) ? m1_rdata[inst] : m0_rdata[inst], cyc);
        if (drop[0]) m0_req[inst] = 1'b0;
        if (drop[1]) m1_req[inst] = 1'b0;
        @(negedge clk);
        check("ack_width", {31'd0, m0_ack[inst] | m1_ack[inst]}, 32'd0);
    endtask

    int w0, r0, k;

    initial begin
        for (int i = 0; i < NI; i++) begin
            m0_req[i] = 0; m0_we[i] = 0; m0_addr[i] = 0; m0_wdata[i] = 0;
            m1_req[i] = 0; m1_we[i] = 0; m1_addr[i] = 0; m1_wdata[i] = 0;
            for (int a = 0; a < 64; a++) ref_mem[i][a] = 32'd0;
        end
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read[1]}, 32'd0);
        check("rst_m0_rdata", m0_rdata[2], 32'd0);
        rst = 1'b1;

        // Both masters requesting continuously from reset: m0, m1, m0, m1 every 3 cycles.
        @(posedge clk); #1;
        k = cyc;
        set_req(0, 0, 1'b1, 32'd30, 32'hA0);
        set_req(0, 1, 1'b1, 32'd31, 32'hB1);
        push_exp(0, 0, 1'b1, 32'd30, 32'hA0, k + 2);
        push_exp(0, 1, 1'b1, 32'd31, 32'hB1, k + 5);
        push_exp(0, 0, 1'b1, 32'd30, 32'hA0, k + 8);
        push_exp(0, 1, 1'b1, 32'd31, 32'hB1, k + 11);
        wait_ack(0, 2'b00);
        wait_ack(0, 2'b00);
        wait_ack(0, 2'b00);
        wait_ack(0, 2'b11);

        // WAIT=0: write then read back addr 17.
        w0 = g_dut[0].wr_cnt;
        issue(0, 0, 1'b1, 32'd17, 32'h38);
        wait_ack(0, 2'b11);
        check("w0_write_cycles", 32'(g_dut[0].wr_cnt - w0), 32'd1);
        issue(0, 0, 1'b0, 32'd17, 32'd0);
        wait_ack(0, 2'b11);

        // Out-of-range write then read at addr 64.
        w0 = g_dut[0].wr_cnt;
        r0 = g_dut[0].rd_cnt;
        issue(0, 0, 1'b1, 32'd64, 32'h55);
        wait_ack(0, 2'b11);
        issue(0, 0, 1'b0, 32'd64, 32'd0);
        wait_ack(0, 2'b11);
        check("oor_no_write", 32'(g_dut[0].wr_cnt - w0), 32'd0);
        check("oor_no_read", 32'(g_dut[0].rd_cnt - r0), 32'd0);

        // WAIT=3: m1 reads addr 15 holding 0x41; m0 rdata must not move.
        issue(1, 0, 1'b1, 32'd15, 32'h41);
        wait_ack(1, 2'b11);
        issue(1, 0, 1'b1, 32'd14, 32'h99);
        wait_ack(1, 2'b11);
        issue(1, 0, 1'b0, 32'd14, 32'd0);
        wait_ack(1, 2'b11);
        r0 = g_dut[1].rd_cnt;
        issue(1, 1, 1'b0, 32'd15, 32'd0);
        wait_ack(1, 2'b11);
        check("w3_read_cycles", 32'(g_dut[1].rd_cnt - r0), 32'd4);
        check("w3_m0_rdata_held", m0_rdata[1], 32'h99);

        // WAIT=2: reset during the ACCESS of a write abandons it.
        issue(2, 0, 1'b1, 32'd5, 32'h11);
        wait_ack(2, 2'b11);
        w0 = g_dut[2].wr_cnt;
        issue(2, 0, 1'b1, 32'd5, 32'hAA);
        void'(exp_q.pop_back());
        ref_mem[2][5] = 32'h11;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m0_req[2] = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy[2]}, 32'd0);
        check("rst_mid_write", {31'd0, mem_write[2]}, 32'd0);
        check("rst_mid_addr", mem_addr[2], 32'd0);
        check("rst_mid_wdata", mem_wdata[2], 32'd0);
        check("rst_clears_rdata", m0_rdata[1], 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_mem_unchanged", g_dut[2].mem[5], 32'h11);
        check("rst_no_commit", 32'(g_dut[2].wr_cnt - w0), 32'd0);

        // After reset, a tie goes to m0 even though m0 was granted last before reset.
        @(posedge clk); #1;
        k = cyc;
        set_req(2, 0, 1'b0, 32'd5, 32'd0);
        set_req(2, 1, 1'b0, 32'd5, 32'd0);
        push_exp(2, 0, 1'b0, 32'd5, 32'd0, k + 4);
        push_exp(2, 1, 1'b0, 32'd5, 32'd0, k + 9);
        wait_ack(2, 2'b01);
        wait_ack(2, 2'b11);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port data memory. Masters 0 and 1 (e.g. the core load/store path and a debug/loader port) issue word requests. The block round-robin arbitrates between them and drives the memory's read enable, write enable, address and write-data inputs through a fixed wait-state sequence. It returns a one-cycle acknowledge with registered read data, or an error for out-of-range addresses.

Parameters:
DEPTH, 64, number of 32-bit words in the data memory; valid word addresses are 0..DEPTH-1.
WAIT, 0, extra wait-state cycles per access, range 0..15.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
m0_req  input  1  master 0 request; held high with fields stable until m0_ack.
m0_we  input  1  master 0 write (1) / read (0).
m0_addr  input  32  master 0 word address.
m0_wdata  input  32  master 0 write data.
m0_ack  output  1  master 0 one-cycle completion pulse.
m0_err  output  1  high with m0_ack when the address is out of range.
m0_rdata  output  32  master 0 read data; registered and held.
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as m0, for master 1.
mem_read  output  1  memory read enable.
mem_write  output  1  memory write enable.
mem_addr  output  32  memory address.
mem_wdata  output  32  memory write data.
mem_rdata  input  32  combinational read data from memory.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, wait counter=0, last_grant=1 (so master 0 wins the first tie). All acks, errs, mem_* and busy=0. m0_rdata=m1_rdata=0. An access in flight is abandoned: a write whose commit edge has not yet occurred is never performed.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - One req: that master wins.
  - Both req: the master that was not last_grant wins.
  - On the edge: latch winner id, we, addr and wdata into internal registers; set cnt=WAIT; go to ACCESS.
  - An address is out of range when addr >= DEPTH; flag it at latch time.
- ACCESS, WAIT+1 cycles (cnt counts WAIT down to 0):
  - mem_addr = latched addr and mem_wdata = latched wdata throughout.
  - Read: mem_read=1 every ACCESS cycle. mem_rdata is captured into the winner's rdata register on the edge leaving the cnt==0 cycle.
  - Write: mem_write=1 only in the cnt==0 cycle, so exactly one commit edge per write.
  - Out-of-range: mem_read=mem_write=0 for all cycles; the winner's rdata register is loaded with 0 for reads and unchanged for writes.
  - When cnt==0, go to RESP; otherwise decrement cnt.
- RESP, one cycle:
  - The winner's ack=1, and its err=1 if out of range.
  - On exit: last_grant=winner; go to IDLE.
- mem_read, mem_write, mem_addr and mem_wdata are all 0 outside ACCESS.
- Latency: request sampled in IDLE cycle N gives ack in cycle N+WAIT+2. Back-to-back accesses take one per WAIT+3 cycles.
- A request still high in the IDLE cycle after its ack is treated as a new request; masters drop req after ack.
- A requester dropping req mid-transaction does not abort it; the access completes as latched.
- The losing master's req is simply held off; no fields are sampled from it.
- rdata registers change only on that master's own read response.

Test Plan:
- WAIT=0, m0 writes 0x38 to addr 17, then m0 reads addr 17 -> mem_write high for exactly 1 cycle; read ack 2 cycles after req; m0_rdata=0x38, m0_err=0.
- WAIT=3, m1 reads addr 15 holding 0x41 -> mem_read high 4 cycles; m1_ack 5 cycles after req; m1_rdata=0x41; m0_rdata unchanged.
- m0 and m1 requesting continuously from reset -> grants alternate m0, m1, m0, m1; each ack one cycle wide; spacing WAIT+3 cycles.
- m0 writes addr 64 (DEPTH=64) -> m0_ack with m0_err=1; mem_write never asserted. A following read of addr 64 gives m0_rdata=0, err=1.
- rst pulsed low during the ACCESS of a write with WAIT=2 -> outputs 0 immediately; memory word unchanged; the first request after release is granted to m0 when both request.
